// File: rtl/uart_rx.sv
// UART receiver: one rxd sample per bit-rate clock, 8N/8E/8O with 1 or 2 stop bits.
// Define UART_RX_SYNC_EN to pass rxd through a 2-flop synchronizer (adds 2 cycles of latency).
module uart_rx (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_en,
  input  logic [1:0] parity_type,
  input  logic       nstop,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_t;

  state_t              present_state_q, present_state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [1:0]          par_cfg_q, par_cfg_d;
  logic                nstop_cfg_q, nstop_cfg_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                parity_error_q, parity_error_d;
  logic                frame_error_q, frame_error_d;
  logic                rx_busy_q, rx_busy_d;
  logic                frame_done;
  logic                rxd_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], rxd};
  assign rxd_s  = sync_q[1];

  // Both stages reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= sync_d;
  end
`else
  assign rxd_s = rxd;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      present_state_q <= IDLE;
      cnt_q           <= '0;
      shift_q         <= '0;
      par_cfg_q       <= '0;
      nstop_cfg_q     <= 1'b0;
      perr_q          <= 1'b0;
      ferr_q          <= 1'b0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      frame_error_q   <= 1'b0;
      rx_busy_q       <= 1'b0;
    end else begin
      present_state_q <= present_state_d;
      cnt_q           <= cnt_d;
      shift_q         <= shift_d;
      par_cfg_q       <= par_cfg_d;
      nstop_cfg_q     <= nstop_cfg_d;
      perr_q          <= perr_d;
      ferr_q          <= ferr_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      frame_error_q   <= frame_error_d;
      rx_busy_q       <= rx_busy_d;
    end
  end

  always_comb begin
    present_state_d = present_state_q;
    cnt_d           = cnt_q;
    shift_d         = shift_q;
    par_cfg_d       = par_cfg_q;
    nstop_cfg_d     = nstop_cfg_q;
    perr_d          = perr_q;
    ferr_d          = ferr_q;
    data_out_d      = data_out_q;
    parity_error_d  = parity_error_q;
    frame_error_d   = frame_error_q;
    data_valid_d    = 1'b0;
    frame_done      = 1'b0;

    case (present_state_q)
      IDLE: begin
        if (rx_en && !rxd_s) begin
          present_state_d = DATA;
          par_cfg_d       = parity_type;
          nstop_cfg_d     = nstop;
          cnt_d           = '0;
          shift_d         = '0;
          perr_d          = 1'b0;
          ferr_d          = 1'b0;
        end
      end
      DATA: begin
        shift_d[cnt_q] = rxd_s;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          present_state_d = par_cfg_q[1] ? PARITY : STOP1;
        end
      end
      PARITY: begin
        perr_d          = rxd_s ^ (^shift_q) ^ par_cfg_q[0];
        present_state_d = STOP1;
      end
      STOP1: begin
        ferr_d = ~rxd_s;
        if (nstop_cfg_q) begin
          present_state_d = STOP2;
        end else begin
          present_state_d = IDLE;
          frame_done      = 1'b1;
        end
      end
      STOP2: begin
        ferr_d          = ferr_q | ~rxd_s;
        present_state_d = IDLE;
        frame_done      = 1'b1;
      end
      default: present_state_d = IDLE;
    endcase

    // Publish the frame on the edge that samples its final stop bit.
    if (frame_done) begin
      data_out_d     = shift_d;
      parity_error_d = perr_d;
      frame_error_d  = ferr_d;
      data_valid_d   = 1'b1;
    end

    rx_busy_d = (present_state_d != IDLE);
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign rx_busy      = rx_busy_q;

endmodule
